two_digit_counter: RTL and testbench
====================================

# two_digit_counter

- Two-digit up/down counter that produces the pair of 4-bit digit values consumed by the two seven-segment decoders on the board (`o_digit_lo` feeds the ones display, `o_digit_hi` the tens display).
- Counts on a free-running prescaled tick and on single-cycle step pulses, for example from a debounced button.
- Supports synchronous clear.
- Flags wrap-around with a one-cycle pulse.

## Interface

Parameters:
- `TICK_DIV`, default 25_000_000: prescaler period in clocks between automatic count ticks (1 Hz at 25 MHz). Legal range is ≥ 2.

Ports:
- `i_clk`  in  1  system clock. This is the only clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_enable`  in  1  enables the prescaler and automatic ticking.
- `i_up`  in  1  count direction: 1 = increment, 0 = decrement.
- `i_step`  in  1  one-cycle pulse that requests a single count. It is honoured regardless of `i_enable`.
- `i_clear`  in  1  synchronous clear of the digits and the prescaler.
- `o_digit_lo`  out  4  ones digit, registered.
- `o_digit_hi`  out  4  tens digit, registered.
- `o_tick`  out  1  one-cycle pulse, high in the cycle in which a prescaler-driven count takes effect.
- `o_wrap`  out  1  one-cycle pulse, high in the cycle in which the digits show a wrapped value.

## Operation

- **Reset values:** `o_digit_lo` = 0, `o_digit_hi` = 0, `o_tick` = 0, `o_wrap` = 0, prescaler = 0.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 while `i_enable` = 1.
  - At the terminal value it returns to 0 and raises an internal tick request.
  - While `i_enable` = 0 it holds its value. It is not reset.
- **Count event:** an event is a tick request OR `i_step`. When both occur in the same cycle, the counter moves by one only, and `o_tick` still pulses.
- **Priority:** `i_clear` > count event > hold.
  - `i_clear` forces both digits and the prescaler to 0.
  - It suppresses `o_tick` and `o_wrap` in that cycle.
- **Increment:**
  - The lo digit increments.
  - At digit max, lo goes to 0 and carries into hi.
  - When hi is also at max, both go to 0 and `o_wrap` pulses.
- **Decrement:**
  - At 0, lo goes to digit max and borrows from hi.
  - From 00 the counter goes to max-max and `o_wrap` pulses.
- **Digit max:** 4'hF (hex) or 4'd9 (BCD), as set under Configuration.
- **Direction:** `i_up` is sampled in the same cycle as the count event. Changing direction mid-run is legal and takes effect on the next event.

## Timing

- **Step latency:** `i_step` high in cycle N gives new digits visible in cycle N+1.
- **Clear latency:** `i_clear` in cycle N gives digits 00 in N+1. A tick that would have occurred in cycle N is discarded.
- **Tick timing:**
  - The prescaler reaches `TICK_DIV`-1 in cycle N.
  - In N+1, `o_tick` = 1 and the digits show the new value.
  - Ticks are spaced exactly `TICK_DIV` enabled clocks apart.
- **Wrap timing:** `o_wrap` is registered alongside the digits and is high for exactly one cycle.
- **Asynchronous reset:** assertion of `i_rst_n` mid-count immediately forces all reset values. After release, the first tick arrives `TICK_DIV` enabled clocks later.
- **Step held high:** `i_step` held high for K cycles produces K counts. Single-pulse generation is the upstream's responsibility.

## Configuration

- Macro `TWO_DIGIT_COUNTER_BCD_EN`.
- **Defined:** decimal counting.
  - Digit max is 9.
  - Sequence 00..99.
  - Wrap 99↔00.
- **Undefined:** hexadecimal counting.
  - Digit max is F.
  - Sequence 00..FF.
  - Wrap FF↔00.
- In both modes the outputs never hold a value above the digit max.

## Structure

- **Shared package `display_pkg`** holds:
  - constants `DIGIT_MAX_HEX` = 4'hF and `DIGIT_MAX_BCD` = 4'd9;
  - `DIGIT_W` = 4;
  - the macro-selected `DIGIT_MAX`.
- **Prescaler width:** computed locally as $clog2(`TICK_DIV`).
- **Sub-module `digit_counter`:** one 4-bit digit with inputs `en`/`up` and outputs `carry`/`borrow`, against `DIGIT_MAX`.
  - Instantiated twice: the lo digit's carry/borrow output drives the hi digit's enable.
  - The wrap output is the AND of both carries/borrows.

## Test plan

All scenarios use `TICK_DIV` = 4.

- **Reset:** hold `i_rst_n` = 0 → digits 00, `o_tick` = 0, `o_wrap` = 0. Release with `i_enable` = 1 → first `o_tick` 4 clocks later, digits 01.
- **Hex increment:** up from 0F plus one `i_step` → 10 next cycle. From FF plus `i_step` → 00 with `o_wrap` = 1 for one cycle.
- **BCD mode (macro defined):** from 09 up → 10. From 99 up → 00 with `o_wrap`. Decrement from 00 → 99 with `o_wrap`. Digits never exceed 9.
- **Coincident step and tick:** `i_step` in the same cycle as a tick request at 05 up → 06 (not 07), `o_tick` = 1.
- **Clear priority:** `i_clear` together with a tick at 3A → 00, `o_tick` = 0, `o_wrap` = 0. The prescaler restarts, and the next tick comes 4 clocks later.
- **Disable and async reset:** deassert `i_enable` for 10 clocks → digits and prescaler frozen, `i_step` still counts. Assert `i_rst_n` mid-cycle → outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants for the seven-segment digit path.
// Define TWO_DIGIT_COUNTER_BCD_EN for decimal digits; hex otherwise.
package display_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX_HEX = 4'hF;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_BCD = 4'd9;

`ifdef TWO_DIGIT_COUNTER_BCD_EN
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_MAX_BCD;
`else
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_MAX_HEX;
`endif

endpackage

// File: rtl/digit_counter.sv
// One up/down display digit that wraps at DIGIT_MAX.
// carry/borrow are combinational and only assert while en is high.
module digit_counter
  import display_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic               up,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry,
  output logic               borrow
);

  logic atMax;
  logic atMin;

  assign atMax  = (digit == DIGIT_MAX);
  assign atMin  = (digit == '0);
  assign carry  = en & up & atMax;
  assign borrow = en & ~up & atMin;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (en) begin
      if (up)
        digit <= atMax ? '0 : digit + DIGIT_W'(1);
      else
        digit <= atMin ? DIGIT_MAX : digit - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/two_digit_counter.sv
// Two-digit up/down counter with prescaled tick, step and clear.
// Define TWO_DIGIT_COUNTER_BCD_EN for 00..99, hex 00..FF otherwise.
module two_digit_counter
  import display_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_up,
  input  logic               i_step,
  input  logic               i_clear,
  output logic [DIGIT_W-1:0] o_digit_lo,
  output logic [DIGIT_W-1:0] o_digit_hi,
  output logic               o_tick,
  output logic               o_wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presCnt;
  logic          tickReq;
  logic          countEv;
  logic          loCarry;
  logic          loBorrow;
  logic          hiCarry;
  logic          hiBorrow;

  assign tickReq = i_enable && (presCnt == LAST);
  assign countEv = tickReq | i_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presCnt <= '0;
    end else if (i_clear) begin
      presCnt <= '0;
    end else if (i_enable) begin
      presCnt <= tickReq ? '0 : presCnt + PW'(1);
    end
  end

  digit_counter uLo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (i_clear),
    .en      (countEv),
    .up      (i_up),
    .digit   (o_digit_lo),
    .carry   (loCarry),
    .borrow  (loBorrow)
  );

  digit_counter uHi (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (i_clear),
    .en      (loCarry | loBorrow),
    .up      (i_up),
    .digit   (o_digit_hi),
    .carry   (hiCarry),
    .borrow  (hiBorrow)
  );

  // hi only carries/borrows when lo did, so this is the AND of both
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_tick <= tickReq & ~i_clear;
      o_wrap <= (hiCarry | hiBorrow) & ~i_clear;
    end
  end

endmodule

// File: tb/tb_two_digit_counter.sv
// Scoreboard bench for two_digit_counter with TICK_DIV = 4.
// Reference model tracks the count as one integer modulo BASE*BASE.
module tb_two_digit_counter;

  localparam int TD = 4;
`ifdef TWO_DIGIT_COUNTER_BCD_EN
  localparam int BASE = 10;
`else
  localparam int BASE = 16;
`endif
  localparam int NV = BASE * BASE;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_up = 1'b1;
  logic       i_step = 1'b0;
  logic       i_clear = 1'b0;
  logic [3:0] o_digit_lo;
  logic [3:0] o_digit_hi;
  logic       o_tick;
  logic       o_wrap;

  int tests = 0;
  int fails = 0;
  int mVal = 0;
  int mPres = 0;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  two_digit_counter #(.TICK_DIV(TD)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_up       (i_up),
    .i_step     (i_step),
    .i_clear    (i_clear),
    .o_digit_lo (o_digit_lo),
    .o_digit_hi (o_digit_hi),
    .o_tick     (o_tick),
    .o_wrap     (o_wrap)
  );

  task automatic chk(input string nm, input exp_t e);
    tests++;
    if (o_digit_lo !== e.lo || o_digit_hi !== e.hi ||
        o_tick !== e.tick || o_wrap !== e.wrap) begin
      fails++;
      $display("FAIL %s @%0t: got hi=%h lo=%h tick=%b wrap=%b, want hi=%h lo=%h tick=%b wrap=%b",
               nm, $time, o_digit_hi, o_digit_lo, o_tick, o_wrap,
               e.hi, e.lo, e.tick, e.wrap);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare just after the edge.
  always @(posedge i_clk) begin
    #1;
    if (sb.size() != 0) chk("scoreboard", sb.pop_front());
  end

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic cyc(input bit en, input bit up, input bit st, input bit cl);
    bit   tickReq;
    exp_t e;
    @(negedge i_clk);
    i_enable = en;
    i_up     = up;
    i_step   = st;
    i_clear  = cl;
    tickReq  = en && (mPres == TD - 1);
    e.tick   = 1'b0;
    e.wrap   = 1'b0;
    if (cl) begin
      mVal  = 0;
      mPres = 0;
    end else begin
      if (en) mPres = (mPres + 1) % TD;
      if (tickReq || st) begin
        if (up) begin
          e.wrap = (mVal == NV - 1);
          mVal   = (mVal + 1) % NV;
        end else begin
          e.wrap = (mVal == 0);
          mVal   = (mVal + NV - 1) % NV;
        end
      end
      e.tick = tickReq;
    end
    e.lo = 4'(mVal % BASE);
    e.hi = 4'(mVal / BASE);
    sb.push_back(e);
  endtask

  task automatic stepTo(input int v);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < v; i++) cyc(0, 1, 1, 0);
  endtask

  task automatic asyncReset();
    exp_t z;
    z.lo = 4'h0; z.hi = 4'h0; z.tick = 1'b0; z.wrap = 1'b0;
    @(posedge i_clk);
    #3;
    i_enable = 1'b0;
    i_step   = 1'b0;
    i_clear  = 1'b0;
    i_rst_n  = 1'b0;
    mVal     = 0;
    mPres    = 0;
    #1;
    chk("async_reset", z);
    repeat (2) @(posedge i_clk);
    #2;
    chk("reset_hold", z);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    exp_t z;
    z.lo = 4'h0; z.hi = 4'h0; z.tick = 1'b0; z.wrap = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    chk("reset_values", z);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // free-running ticks from reset
    repeat (10) cyc(1, 1, 0, 0);

    // carry from lo to hi, then full wrap
    stepTo(BASE - 1);
    cyc(0, 1, 1, 0);
    stepTo(NV - 1);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);

    // borrow wrap from 00
    stepTo(0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // step coincident with a tick moves by one
    stepTo(5);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);

    // clear on a tick cycle, then prescaler restart
    stepTo(58);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    repeat (5) cyc(1, 1, 0, 0);

    // disabled: frozen except for steps
    repeat (2) cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, (i % 3) == 0, 0);
    repeat (6) cyc(1, 0, 0, 0);

    // async reset mid-count, then ticks resume from a fresh prescaler
    asyncReset();
    repeat (9) cyc(1, 1, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 4) == 0,
          ($urandom % 60) == 0);
      if (i == 1000) asyncReset();
    end

    repeat (2) @(posedge i_clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
